// File: rtl/coax_pkg.sv
// Shared coax definitions: word width and the transmit-queue FSM state encoding.
package coax_pkg;

   localparam int unsigned COAX_WORD_WIDTH = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_ACK,
      BUSY,
      GAP
   } coax_tx_queue_state_t;

endpackage

// File: rtl/coax_fifo.sv
// Circular word buffer with extra-bit pointers, registered occupancy flags,
// overflow detection and synchronous flush.
module coax_fifo
   import coax_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [COAX_WORD_WIDTH-1:0] wr_data,
   input  logic                       rd_en,
   input  logic                       flush,
   output logic [COAX_WORD_WIDTH-1:0] rd_data_c,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [COAX_WORD_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]              wr_ptr;
   logic [CW-1:0]              rd_ptr;
   logic [CW-1:0]              wr_ptr_nxt_c;
   logic [CW-1:0]              rd_ptr_nxt_c;
   logic [CW-1:0]              count_nxt_c;
   logic                       push_c;
   logic                       pop_c;

   // Full is judged on the registered flag, so a write while full is refused even if a pop happens.
   always_comb begin
      push_c       = wr_en & ~full & ~flush;
      pop_c        = rd_en & ~empty;
      overflow_c   = wr_en & full & ~flush;
      wr_ptr_nxt_c = push_c ? wr_ptr + CW'(1) : wr_ptr;
      rd_ptr_nxt_c = pop_c ? rd_ptr + CW'(1) : rd_ptr;
      count_nxt_c  = wr_ptr_nxt_c - rd_ptr_nxt_c;
      rd_data_c    = mem[rd_ptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr_nxt_c;
         rd_ptr <= rd_ptr_nxt_c;
         count  <= count_nxt_c;
         full   <= (count_nxt_c == CW'(DEPTH));
         empty  <= (count_nxt_c == '0);
      end
   end

endmodule

// File: rtl/coax_tx_queue.sv
// Transmit word queue feeding coax_tx: load handshake, ack timeout, inter-word gap.
// Optional COAX_TX_QUEUE_STATS_EN adds sent_count / drop_count statistics outputs.
module coax_tx_queue
   import coax_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned GAP_CYCLES  = 8,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [COAX_WORD_WIDTH-1:0] wr_data,
   input  logic                       flush,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       tx_load,
   output logic [COAX_WORD_WIDTH-1:0] tx_data,
   input  logic                       tx_active,
   output logic                       overflow,
   output logic                       timeout,
   input  logic                       clear_err
`ifdef COAX_TX_QUEUE_STATS_EN
   ,
   output logic [15:0]                sent_count,
   output logic [7:0]                 drop_count
`endif
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

   coax_tx_queue_state_t       state_q;
   coax_tx_queue_state_t       state_d;
   logic [TW-1:0]              ack_tmr_q;
   logic [TW-1:0]              ack_tmr_d;
   logic [GW-1:0]              gap_q;
   logic [GW-1:0]              gap_d;
   logic                       pop_c;
   logic                       timeout_evt_c;
   logic                       sent_evt_c;
   logic                       overflow_evt_c;
   logic [COAX_WORD_WIDTH-1:0] head_c;

   coax_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_en      (pop_c),
      .flush      (flush),
      .rd_data_c  (head_c),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .overflow_c (overflow_evt_c)
   );

   // Ack timer counts clocks since tx_load, so it reads k in the k-th cycle after the strobe.
   always_comb begin
      state_d       = state_q;
      ack_tmr_d     = ack_tmr_q;
      gap_d         = gap_q;
      pop_c         = 1'b0;
      timeout_evt_c = 1'b0;
      sent_evt_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && !tx_active) begin
               pop_c   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            ack_tmr_d = TW'(1);
            state_d   = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_active) begin
               state_d = BUSY;
            end else if (ack_tmr_q >= TW'(ACK_TIMEOUT - 1)) begin
               timeout_evt_c = 1'b1;
               gap_d         = GW'(GAP_CYCLES);
               state_d       = GAP;
            end else begin
               ack_tmr_d = ack_tmr_q + TW'(1);
            end
         end
         BUSY: begin
            if (!tx_active) begin
               sent_evt_c = 1'b1;
               gap_d      = GW'(GAP_CYCLES);
               state_d    = GAP;
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ack_tmr_q <= '0;
         gap_q     <= '0;
         tx_load   <= 1'b0;
         tx_data   <= '0;
         overflow  <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ack_tmr_q <= ack_tmr_d;
         gap_q     <= gap_d;
         tx_load   <= (state_d == LOAD);
         if (pop_c) begin
            tx_data <= head_c;
         end
         // A new error in the same cycle as clear_err keeps the flag set.
         overflow  <= overflow_evt_c | (overflow & ~clear_err);
         timeout   <= timeout_evt_c | (timeout & ~clear_err);
      end
   end

`ifdef COAX_TX_QUEUE_STATS_EN
   logic [8:0] drop_sum_c;

   always_comb begin
      drop_sum_c = 9'(drop_count) + 9'(overflow_evt_c) + 9'(timeout_evt_c);
   end

   // sent_count wraps; drop_count saturates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sent_count <= '0;
         drop_count <= '0;
      end else begin
         if (sent_evt_c) begin
            sent_count <= sent_count + 16'd1;
         end
         drop_count <= drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
      end
   end
`endif

endmodule

// File: doc/coax_tx_queue.md
# coax_tx_queue

Transmit word queue that sits directly upstream of `coax_tx`. It buffers 10-bit coax words written by the host-side logic and hands them to `coax_tx` one at a time. It drives the `load` strobe only when the transmitter is idle, waits for `active` to confirm acceptance, and enforces a minimum inter-word gap. It replaces the free-running counter that currently strobes `load` in the top level.

## Interface

Parameters:
- `DEPTH`, 16: queue capacity in words; power of two, 2..256.
- `GAP_CYCLES`, 8: minimum idle clocks between `active` falling and the next `load`; 0 allowed.
- `ACK_TIMEOUT`, 64: clocks to wait for `active` after `load` before flagging an error.

Ports:
- `clk`  in  1  system clock (19 MHz PLL output).
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push `wr_data` into the queue this cycle.
- `wr_data`  in  10  coax word to enqueue.
- `flush`  in  1  synchronous discard of all queued words.
- `full`  out  1  queue holds `DEPTH` words.
- `empty`  out  1  queue holds 0 words.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `tx_load`  out  1  one-cycle strobe to `coax_tx.load`.
- `tx_data`  out  10  word presented to `coax_tx.data`; held stable from `tx_load` until `tx_active` falls.
- `tx_active`  in  1  from `coax_tx.active`.
- `overflow`  out  1  sticky: a write was attempted while full.
- `timeout`  out  1  sticky: `tx_active` did not rise within `ACK_TIMEOUT`.
- `clear_err`  in  1  clears `overflow` and `timeout`.

Reset values: `tx_load`=0, `tx_data`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0, `timeout`=0, state=IDLE.

## Operation

- Storage is a circular buffer with read and write pointers one bit wider than the address. Pointers wrap modulo `DEPTH`.
- A write when `full` is dropped, sets `overflow`, and leaves the contents unchanged.
- When `full`, a write and a pop in the same cycle are still treated as overflow. Full is evaluated before the pop.
- A write when `empty` is visible to the FSM on the following cycle.
- FSM states:
  - IDLE: if not `empty` and `tx_active`=0, pop the head into `tx_data` and go to LOAD.
  - LOAD: assert `tx_load` for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: on `tx_active`=1, go to BUSY. If the timer reaches `ACK_TIMEOUT`, set `timeout` and go to GAP; the word is dropped, not retried.
  - BUSY: on `tx_active`=0, load the gap counter and go to GAP.
  - GAP: count down `GAP_CYCLES`, then go to IDLE. With `GAP_CYCLES`=0, GAP lasts a single cycle.
- `flush` empties the queue (pointers equal, `count`=0) in any state. It does not abort a word already popped; the FSM completes that word normally.
- `flush` and `wr_en` in the same cycle: the flush wins and the written word is discarded.
- `clear_err` and a new error event in the same cycle: the error wins, so the flag stays set.
- Asserting `reset_n` low mid-transfer returns all state to reset values immediately. `tx_load` never glitches high during reset.

## Timing

- Latency from a write to an empty queue (FSM in IDLE, `tx_active`=0) to `tx_load` high: 2 cycles. The write lands in cycle N, the pop in N+1, and `tx_load` is high in N+2.
- `tx_data` is valid in the same cycle as `tx_load` and stays constant through BUSY.
- Word-to-word spacing is the `coax_tx` active time plus `GAP_CYCLES`+1 plus 2 cycles of overhead.
- `count`, `full` and `empty` are registered and update one cycle after the write or pop.

## Configuration

- `COAX_TX_QUEUE_STATS_EN`:
  - Defined: adds an output `sent_count` (16 bits, reset 0) that increments on each BUSY→GAP transition and wraps at 0xFFFF→0. It also adds an output `drop_count` (8 bits, reset 0) that increments on each overflow or timeout event and saturates at 0xFF.
  - Undefined: both ports and their counters are absent, and all other behaviour is identical.

## Structure

- Shared package `coax_pkg` holds:
  - `COAX_WORD_WIDTH`=10.
  - The FSM state enum `coax_tx_queue_state_t` (IDLE, LOAD, WAIT_ACK, BUSY, GAP).
- One sub-module, `coax_fifo`: a parameterised synchronous FIFO providing storage, pointers, `count`, `full`, `empty`, overflow detection and flush. The FSM, timers and error flags live in `coax_tx_queue`.

## Test plan

- Single word: write 0x005 with a `coax_tx` model that raises `tx_active` 2 cycles after load for 20 cycles. Expect `tx_load` 2 cycles after the write with `tx_data`=0x005, and `empty`=1 after the pop.
- Burst: write 4 words (0x101, 0x102, 0x103, 0x104) back to back with `GAP_CYCLES`=8. Expect 4 loads in order, each at least 9 cycles after the previous `tx_active` fall.
- Overflow: fill 16 words with `tx_active` held at 1, then write a 17th. Expect `full`=1, `overflow`=1 and `count`=16, with the 17th word never transmitted.
- Timeout: the model never raises `tx_active`. Expect `timeout`=1 exactly 64 cycles after `tx_load`, then the next word loads after the gap.
- Flush and reset: queue 5 words, flush during BUSY of word 1, and expect only word 1 to complete. Then pull `reset_n` low mid-BUSY and expect all outputs at their reset values within the same cycle.
- Stats (macro defined): send 3 words and cause 1 timeout. Expect `sent_count`=3 and `drop_count`=1.
